// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: NUM_DIGITS-digit BCD up/down counter with pause, synchronous
// clamped load, rollover pulse, LED bank tap and a time-multiplexed, active-low
// 7-segment scan driver. Outputs are all registered and drive board pins directly.
module bcd_scan_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int LED_W      = 8,
  parameter bit BLANK_LZ   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pause_n,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [LED_W-1:0]        LED,
  output logic [7:0]              digit,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic                    wrap
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  // Active-low segment pattern (dp in bit 7 stays dark).
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;
  logic [CW-1:0]         step_val;
  logic [CW-1:0]         load_clamped;
  logic [TW-1:0]         tick_cnt_reg;
  logic [SW-1:0]         scan_cnt_reg;
  logic [IW-1:0]         scan_idx_reg;
  logic [IW-1:0]         scan_idx_next;
  logic                  wrap_reg;
  logic                  wrap_next;
  logic [NUM_DIGITS-1:0] sel_reg;
  logic [7:0]            digit_reg;

  logic                  tick;
  logic                  scan_adv;
  logic [NUM_DIGITS-1:0] at_limit;    // digit is 9 (counting up) or 0 (counting down)
  logic [NUM_DIGITS-1:0] digit_zero;
  logic [NUM_DIGITS:0]   chain;       // carry (up) / borrow (down) into each digit
  logic [NUM_DIGITS:0]   zero_above;  // this digit and all more-significant ones are 0
  logic [7:0]            seg_arr [NUM_DIGITS];

  assign tick     = pause_n && (tick_cnt_reg == TICK_MAX);
  assign scan_adv = (scan_cnt_reg == SCAN_MAX);

  // Per-digit step, load clamp and segment pattern.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      logic [3:0] ld;
      logic       blank;

      assign cur             = count_reg[4*gi +: 4];
      assign ld              = load_val[4*gi +: 4];
      assign at_limit[gi]    = up ? (cur == 4'd9) : (cur == 4'd0);
      assign digit_zero[gi]  = (cur == 4'd0);

      assign step_val[4*gi +: 4] =
          !chain[gi] ? cur :
          up         ? ((cur == 4'd9) ? 4'd0 : cur + 4'd1) :
                       ((cur == 4'd0) ? 4'd9 : cur - 4'd1);

      assign load_clamped[4*gi +: 4] = (ld > 4'd9) ? 4'd9 : ld;

      // Digit 0 always shows, so a zero count still reads "0".
      assign blank       = BLANK_LZ && (gi != 0) && zero_above[gi];
      assign seg_arr[gi] = blank ? 8'hFF : seg7(cur);
    end
  endgenerate

  // Ripple carry/borrow upward and leading-zero detection downward.
  always_comb begin
    chain      = '0;
    zero_above = '0;
    chain[0]   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      chain[i+1] = chain[i] & at_limit[i];
    end
    zero_above[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above[i] = digit_zero[i] & zero_above[i+1];
    end
  end

  // Load beats a coincident tick; a rollover only pulses wrap when the step is kept.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = load_clamped;
    end else if (tick) begin
      count_next = step_val;
      wrap_next  = chain[NUM_DIGITS];
    end
  end

  // Scan index advances once per SCAN_DIV cycles, wrapping after the last digit.
  always_comb begin
    scan_idx_next = scan_idx_reg;
    if (scan_adv) begin
      scan_idx_next = (scan_idx_reg == IDX_MAX) ? '0 : scan_idx_reg + IW'(1);
    end
  end

  // Tick prescaler: frozen (not cleared) while paused, free-running otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
    end else if (pause_n) begin
      tick_cnt_reg <= (tick_cnt_reg == TICK_MAX) ? '0 : tick_cnt_reg + TW'(1);
    end
  end

  // BCD count register and rollover pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Scan prescaler, index and registered display outputs (sel/digit move together).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= '0;
      sel_reg      <= ~NUM_DIGITS'(1);
      digit_reg    <= 8'hC0;
    end else begin
      scan_cnt_reg <= scan_adv ? '0 : scan_cnt_reg + SW'(1);
      scan_idx_reg <= scan_idx_next;
      sel_reg      <= ~(NUM_DIGITS'(1) << scan_idx_next);
      digit_reg    <= seg_arr[scan_idx_next];
    end
  end

  assign LED   = count_reg[LED_W-1:0];
  assign wrap  = wrap_reg;
  assign sel   = sel_reg;
  assign digit = digit_reg;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter. Stimulus pushes hand-computed expectations
// tagged with the cycle they apply to; a monitor pops and compares them each sample.
// Instance a (LED_W=16, no blanking) exposes the whole count on LED; instance b
// (LED_W=8, leading-zero blanking) covers the blanked display and 8-bit LED bank.
module tb_bcd_scan_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pause_n = 1'b1;
  logic        up = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;

  logic [15:0] led_a;
  logic [7:0]  led_b;
  logic [7:0]  digit_a, digit_b;
  logic [3:0]  sel_a, sel_b;
  logic        wrap_a, wrap_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;

  typedef enum int {K_COUNT, K_WRAP, K_SEL, K_DIG_A, K_DIG_B, K_LED_B} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;

  bcd_scan_counter #(
    .NUM_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(3), .LED_W(16), .BLANK_LZ(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .pause_n(pause_n), .up(up), .load(load),
    .load_val(load_val), .LED(led_a), .digit(digit_a), .sel(sel_a), .wrap(wrap_a)
  );

  bcd_scan_counter #(
    .NUM_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(3), .LED_W(8), .BLANK_LZ(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pause_n(pause_n), .up(up), .load(load),
    .load_val(load_val), .LED(led_b), .digit(digit_b), .sel(sel_b), .wrap(wrap_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Regular sample point, 1 time unit after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    ->sample_ev;
  end

  // Monitor: pop every expectation due by now and compare with the DUT outputs.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        case (e.kind)
          K_COUNT: act = led_a;
          K_WRAP:  act = {15'b0, wrap_a};
          K_SEL:   act = {12'b0, sel_a};
          K_DIG_A: act = {8'b0, digit_a};
          K_DIG_B: act = {8'b0, digit_b};
          default: act = {8'b0, led_b};
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s rel=%0d got=%h want=%h", e.name, e.cyc - base, act, e.val);
        end else begin
          $display("ok   %s rel=%0d value=%h", e.name, e.cyc - base, act);
        end
      end
    end
  end

  task automatic push_abs(input int c, input kind_e k, input logic [15:0] v, input string n);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic push_exp(input int r, input kind_e k, input logic [15:0] v, input string n);
    push_abs(base + r, k, v, n);
  endtask

  // Advance to the falling edge that follows rising edge number r after release.
  task automatic goto(input int r);
    if (cyc - base > r) begin
      checks++;
      errors++;
      $display("FAIL goto rel=%0d target=%0d", cyc - base, r);
    end else begin
      while (cyc - base < r) @(negedge clk);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, sampled while reset is still held.
    repeat (3) @(negedge clk);
    push_abs(cyc + 1, K_COUNT, 16'h0000, "rst_count");
    push_abs(cyc + 1, K_WRAP,  16'h0000, "rst_wrap");
    push_abs(cyc + 1, K_SEL,   16'h000E, "rst_sel");
    push_abs(cyc + 1, K_DIG_A, 16'h00C0, "rst_digit_a");
    push_abs(cyc + 1, K_DIG_B, 16'h00C0, "rst_digit_b");
    push_abs(cyc + 1, K_LED_B, 16'h0000, "rst_led_b");
    @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;

    // Count up: one step per 4 cycles, first step on edge 4.
    push_exp(3,   K_COUNT, 16'h0000, "up_before_first");
    push_exp(4,   K_COUNT, 16'h0001, "up_first_step");
    push_exp(156, K_COUNT, 16'h0039, "up_39");
    push_exp(160, K_COUNT, 16'h0040, "up_40");
    push_exp(160, K_WRAP,  16'h0000, "up_40_nowrap");
    push_exp(160, K_LED_B, 16'h0040, "up_40_led8");

    // Rollover up from 9998.
    goto(161);
    load_val = 16'h9998; load = 1'b1;
    push_exp(162, K_COUNT, 16'h9998, "ld_9998");
    push_exp(164, K_COUNT, 16'h9999, "roll_up_9999");
    push_exp(167, K_WRAP,  16'h0000, "roll_up_wrap_pre");
    push_exp(168, K_COUNT, 16'h0000, "roll_up_0000");
    push_exp(168, K_WRAP,  16'h0001, "roll_up_wrap");
    push_exp(168, K_LED_B, 16'h0000, "roll_up_led8");
    push_exp(169, K_WRAP,  16'h0000, "roll_up_wrap_post");
    goto(162);
    load = 1'b0;

    // Rollover down from 0001, then clamped load.
    goto(169);
    load_val = 16'h0001; load = 1'b1; up = 1'b0;
    push_exp(170, K_COUNT, 16'h0001, "ld_0001");
    push_exp(172, K_COUNT, 16'h0000, "roll_dn_0000");
    push_exp(172, K_WRAP,  16'h0000, "roll_dn_nowrap");
    push_exp(176, K_COUNT, 16'h9999, "roll_dn_9999");
    push_exp(176, K_WRAP,  16'h0001, "roll_dn_wrap");
    push_exp(177, K_WRAP,  16'h0000, "roll_dn_wrap_post");
    goto(170);
    load = 1'b0;
    goto(177);
    load_val = 16'hA3F5; load = 1'b1;
    push_exp(178, K_COUNT, 16'h9395, "ld_clamp");
    push_exp(180, K_COUNT, 16'h9394, "dn_after_clamp");
    goto(178);
    load = 1'b0;

    // Pause with prescaler at 1 for 20 cycles; direction flips to up meanwhile.
    goto(181);
    pause_n = 1'b0; up = 1'b1;
    push_exp(189, K_SEL,   16'h0007, "pause_sel3");
    push_exp(190, K_COUNT, 16'h9394, "pause_hold_a");
    push_exp(192, K_SEL,   16'h000E, "pause_sel0");
    push_exp(195, K_SEL,   16'h000D, "pause_sel1");
    push_exp(201, K_COUNT, 16'h9394, "pause_hold_b");
    goto(201);
    pause_n = 1'b1;
    push_exp(203, K_COUNT, 16'h9394, "resume_pre");
    push_exp(204, K_COUNT, 16'h9395, "resume_step");
    push_exp(208, K_COUNT, 16'h9396, "resume_next");

    // Load on a tick cycle: load wins, prescaler still wraps.
    goto(211);
    load_val = 16'h1234; load = 1'b1;
    push_exp(212, K_COUNT, 16'h1234, "collide_load");
    push_exp(212, K_WRAP,  16'h0000, "collide_nowrap");
    push_exp(215, K_COUNT, 16'h1234, "collide_hold");
    push_exp(216, K_COUNT, 16'h1235, "collide_next");
    goto(212);
    load = 1'b0;

    // Scan and blanking on a held 0042 (load accepted while paused).
    goto(217);
    load_val = 16'h0042; load = 1'b1; pause_n = 1'b0;
    push_exp(218, K_COUNT, 16'h0042, "ld_paused");
    push_exp(228, K_SEL,   16'h000E, "scan_sel0");
    push_exp(228, K_DIG_A, 16'h00A4, "scan_d0");
    push_exp(228, K_DIG_B, 16'h00A4, "scan_d0_lz");
    push_exp(231, K_SEL,   16'h000D, "scan_sel1");
    push_exp(231, K_DIG_A, 16'h0099, "scan_d1");
    push_exp(231, K_DIG_B, 16'h0099, "scan_d1_lz");
    push_exp(234, K_SEL,   16'h000B, "scan_sel2");
    push_exp(234, K_DIG_A, 16'h00C0, "scan_d2");
    push_exp(234, K_DIG_B, 16'h00FF, "scan_d2_lz");
    push_exp(237, K_SEL,   16'h0007, "scan_sel3");
    push_exp(237, K_DIG_A, 16'h00C0, "scan_d3");
    push_exp(237, K_DIG_B, 16'h00FF, "scan_d3_lz");
    push_exp(237, K_LED_B, 16'h0042, "scan_led8");
    goto(218);
    load = 1'b0;

    // Asynchronous reset between edges: outputs clear before the next edge.
    goto(239);
    #2;
    rst_n = 1'b0;
    #1;
    push_abs(cyc, K_COUNT, 16'h0000, "async_rst_count");
    push_abs(cyc, K_WRAP,  16'h0000, "async_rst_wrap");
    push_abs(cyc, K_SEL,   16'h000E, "async_rst_sel");
    push_abs(cyc, K_DIG_A, 16'h00C0, "async_rst_digit_a");
    push_abs(cyc, K_DIG_B, 16'h00C0, "async_rst_digit_b");
    ->sample_ev;
    #1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
